// File: rtl/sephirot_stack_pkg.sv
// Shared definitions for the Sephirot eBPF stack and its per-lane access units.
package sephirot_stack_pkg;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_H  = 2'd1,
    SZ_W  = 2'd2,
    SZ_DW = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_RD,
    ST_WT,
    ST_LDR,
    ST_WR
  } stack_state_e;

  localparam int unsigned MAX_ENTRIES = 64;
  localparam int unsigned STACK_BYTES = MAX_ENTRIES * 8;

  // Ceiling log2; also used by stack for its address width.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stack_byte_merge.sv
// Field extraction and read-modify-write merge for one 64-bit stack word.
module stack_byte_merge
  import sephirot_stack_pkg::*;
#(
  parameter int unsigned value_size = 64
) (
  input  logic [value_size-1:0] word,
  input  logic [2:0]            byte_off,
  input  size_e                 size,
  input  logic [value_size-1:0] wdata,
  output logic [value_size-1:0] field,
  output logic [value_size-1:0] merged
);

  logic [value_size-1:0] mask;
  logic [5:0]            shamt;

  // Size mask, shift to the byte lane, extract and merge little-endian.
  always_comb begin
    mask = '0;
    case (size)
      SZ_B:    mask[7:0]  = '1;
      SZ_H:    mask[15:0] = '1;
      SZ_W:    mask[31:0] = '1;
      default: mask       = '1;
    endcase
    shamt  = {byte_off, 3'b000};
    field  = (word >> shamt) & mask;
    merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/stack_lane_port.sv
// One lane's byte-addressed stack load/store unit driving a word-wide port pair.
module stack_lane_port
  import sephirot_stack_pkg::*;
#(
  parameter int unsigned value_size  = 64,
  parameter int unsigned max_entries = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic [63:0]           req_addr,
  input  logic [value_size-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [value_size-1:0] resp_data,
  output logic                  resp_err,
  output logic [63:0]           read_add,
  input  logic [value_size-1:0] data_out,
  output logic [63:0]           wrt_add,
  output logic                  wrt_en,
  output logic [value_size-1:0] data_in
);

  localparam int unsigned AW          = log2(max_entries);
  localparam logic [63:0] STACK_LIMIT = 64'(max_entries * 8);

  stack_state_e          state_q, state_d;
  logic                  wr_q;
  size_e                 size_q;
  logic [2:0]            byte_q;
  logic [AW-1:0]         word_q;
  logic [value_size-1:0] wdata_q;
  logic [value_size-1:0] data_q;
  logic [63:0]           read_add_q;

  logic [2:0]            align_mask;
  logic                  req_err;
  logic                  req_dw_store;
  logic                  accept;
  logic [value_size-1:0] field;
  logic [value_size-1:0] merged;

  // Request classification: alignment/range error and dword-store bypass.
  always_comb begin
    align_mask = '0;
    case (size_e'(req_size))
      SZ_B:    align_mask = 3'd0;
      SZ_H:    align_mask = 3'd1;
      SZ_W:    align_mask = 3'd3;
      default: align_mask = 3'd7;
    endcase
    req_err      = (req_addr >= STACK_LIMIT) || ((req_addr[2:0] & align_mask) != 3'd0);
    req_dw_store = req_wr && (size_e'(req_size) == SZ_DW);
    accept       = (state_q == ST_IDLE) && req_valid;
  end

  stack_byte_merge #(
    .value_size(value_size)
  ) u_merge (
    .word    (data_out),
    .byte_off(byte_q),
    .size    (size_q),
    .wdata   (wdata_q),
    .field   (field),
    .merged  (merged)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    wrt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !reset;
        if (req_valid) begin
          if (req_err)           state_d = ST_ERR;
          else if (req_dw_store) state_d = ST_WR;
          else                   state_d = ST_RD;
        end
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_RD:  state_d = ST_WT;
      ST_WT:  state_d = wr_q ? ST_WR : ST_LDR;
      ST_LDR: begin
        resp_valid = 1'b1;
        resp_data  = data_q;
        state_d    = ST_IDLE;
      end
      ST_WR: begin
        wrt_en     = 1'b1;
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // read_add is loaded on acceptance so the word index is already on the
  // port during RD; data_q doubles as load result and merged store word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      size_q     <= SZ_B;
      byte_q     <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      read_add_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        size_q  <= size_e'(req_size);
        byte_q  <= req_addr[2:0];
        word_q  <= req_addr[AW+2:3];
        wdata_q <= req_wdata;
        if (req_dw_store) data_q <= req_wdata;
        if (!req_err && !req_dw_store) read_add_q <= 64'(req_addr[AW+2:3]);
      end
      if (state_q == ST_WT) data_q <= wr_q ? merged : field;
    end
  end

  // Word-port address/data; upper index bits are always zero.
  always_comb begin
    wrt_add         = '0;
    wrt_add[AW-1:0] = word_q;
    read_add        = read_add_q;
    data_in         = data_q;
  end

endmodule

// File: tb/tb_stack_lane_port.sv
// Randomized self-checking bench for stack_lane_port with a byte-array stack model.
module tb_stack_lane_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [63:0] read_add;
  logic [63:0] data_out;
  logic [63:0] wrt_add;
  logic        wrt_en;
  logic [63:0] data_in;

  always #5 clk = ~clk;

  stack_lane_port #(
    .value_size (64),
    .max_entries(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .read_add  (read_add),
    .data_out  (data_out),
    .wrt_add   (wrt_add),
    .wrt_en    (wrt_en),
    .data_in   (data_in)
  );

  // Stack memory seen by the DUT: registered read, synchronous write.
  logic [63:0] smem [64] = '{default: '0};
  always @(posedge clk) begin
    if (wrt_en) smem[wrt_add[5:0]] <= data_in;
    data_out <= smem[read_add[5:0]];
  end

  typedef struct {
    bit          rdy;
    bit          rv;
    bit          re;
    logic [63:0] rd;
    bit          we;
    logic [63:0] wa;
    logic [63:0] wd;
    logic [63:0] ra;
    bit          pin_en;
    int          pin_sel;   // 0 resp_data, 1 data_in, 2 resp_err, 3 wrt_add
    logic [63:0] pin_val;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  rmem [512];
  logic [63:0] model_ra;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Single compare process: zero outputs during reset, model expectations otherwise.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (reset) begin
      chk("rst_req_ready",  64'(req_ready),  64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err",   64'(resp_err),   64'd0);
      chk("rst_resp_data",  resp_data,       64'd0);
      chk("rst_wrt_en",     64'(wrt_en),     64'd0);
      chk("rst_wrt_add",    wrt_add,         64'd0);
      chk("rst_data_in",    data_in,         64'd0);
      chk("rst_read_add",   read_add,        64'd0);
    end else if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("req_ready",  64'(req_ready),  64'(e.rdy));
      chk("resp_valid", 64'(resp_valid), 64'(e.rv));
      chk("resp_err",   64'(resp_err),   64'(e.re));
      chk("resp_data",  resp_data,       e.rd);
      chk("wrt_en",     64'(wrt_en),     64'(e.we));
      chk("read_add",   read_add,        e.ra);
      if (e.we) begin
        chk("wrt_add", wrt_add, e.wa);
        chk("data_in", data_in, e.wd);
      end
      if (e.pin_en) begin
        case (e.pin_sel)
          0:       chk("pin_resp_data", resp_data,        e.pin_val);
          1:       chk("pin_data_in",   data_in,          e.pin_val);
          2:       chk("pin_resp_err",  64'(resp_err),    e.pin_val);
          default: chk("pin_wrt_add",   wrt_add,          e.pin_val);
        endcase
      end
    end
  end

  function automatic exp_t blank(input bit rdy);
    exp_t e;
    e.rdy = rdy; e.rv = 0; e.re = 0; e.rd = '0; e.we = 0; e.wa = '0; e.wd = '0;
    e.ra = model_ra; e.pin_en = 0; e.pin_sel = 0; e.pin_val = '0;
    return e;
  endfunction

  function automatic logic [63:0] ref_word(input int base);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = rmem[base + i];
    return w;
  endfunction

  task automatic idle_cycle();
    expq.push_back(blank(1'b1));
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // One request with optional literal pin on the response cycle.
  task automatic issue(input bit wr, input logic [1:0] sz, input logic [63:0] addr,
                       input logic [63:0] wd, input bit pin_en, input int pin_sel,
                       input logic [63:0] pin_val);
    int unsigned n;
    bit          err;
    int          lat;
    int          a;
    logic [63:0] ld;
    logic [63:0] mw;
    exp_t        e;
    n   = 32'd1 << sz;
    err = (addr >= 64'd512) || ((addr % 64'(n)) != 64'd0);
    a   = int'(addr[8:0]);
    ld  = '0;
    mw  = '0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < int'(n); i++) rmem[a + i] = wd[8*i +: 8];
        mw = ref_word(a & ~7);
      end else begin
        for (int i = 0; i < int'(n); i++) ld[8*i +: 8] = rmem[a + i];
      end
    end
    lat = (err || (wr && sz == 2'd3)) ? 1 : 3;
    expq.push_back(blank(1'b1));
    if (!err && !(wr && sz == 2'd3)) model_ra = addr >> 3;
    for (int c = 1; c < lat; c++) expq.push_back(blank(1'b0));
    e         = blank(1'b0);
    e.rv      = 1'b1;
    e.re      = err;
    e.rd      = (!err && !wr) ? ld : 64'd0;
    e.we      = !err && wr;
    e.wa      = addr >> 3;
    e.wd      = mw;
    e.pin_en  = pin_en;
    e.pin_sel = pin_sel;
    e.pin_val = pin_val;
    expq.push_back(e);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    for (int c = 0; c < lat; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_addr  = 64'($urandom_range(0, 511));
      req_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Partial store aborted by reset during its WT cycle; nothing may be written.
  task automatic reset_mid_store(input logic [63:0] addr, input logic [63:0] wd);
    expq.push_back(blank(1'b1));
    model_ra = addr >> 3;
    expq.push_back(blank(1'b0));
    expq.push_back(blank(1'b0));
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd0; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    model_ra = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int          k;
    for (int i = 0; i < 512; i++) rmem[i] = 8'h00;
    model_ra  = '0;
    reset     = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    issue(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 1'b1, 1, 64'h1122334455667788);
    idle_cycle();
    issue(1'b0, 2'd3, 64'h10, 64'h0, 1'b1, 0, 64'h1122334455667788);
    issue(1'b1, 2'd0, 64'h13, 64'hAB, 1'b1, 1, 64'h11223344AB667788);
    issue(1'b0, 2'd1, 64'h16, 64'h0, 1'b1, 0, 64'h0000000000001122);
    issue(1'b0, 2'd2, 64'h12, 64'h0, 1'b1, 2, 64'd1);
    issue(1'b0, 2'd0, 64'h200, 64'h0, 1'b1, 2, 64'd1);
    issue(1'b1, 2'd0, 64'h08, 64'h5A, 1'b1, 3, 64'd1);
    issue(1'b0, 2'd0, 64'h08, 64'h0, 1'b1, 0, 64'h5A);
    reset_mid_store(64'h20, 64'hFF);
    issue(1'b0, 2'd0, 64'h20, 64'h0, 1'b1, 0, 64'h0);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
      end else begin
        sz = 2'($urandom_range(0, 3));
        k  = $urandom_range(0, 9);
        if (k < 6)       a = 64'($urandom_range(0, 511)) & ~((64'd1 << sz) - 64'd1);
        else if (k < 8)  a = 64'($urandom_range(0, 511));
        else if (k == 8) a = 64'($urandom_range(500, 530));
        else             a = {$urandom, $urandom};
        issue(1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom}, 1'b0, 0, 64'd0);
      end
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_lane_port.md
# stack_lane_port

Per-lane stack access unit for the Sephirot eBPF core. Converts one lane's byte-addressed eBPF stack load/store request (sizes 1/2/4/8 bytes) into 64-bit word accesses on one read/write port pair of the 4-port stack memory. It sits directly upstream of `stack`; four instances, one per lane, drive its ports.
- Partial stores are done as read-modify-write.
- Loads return zero-extended data.
- Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
- value_size, 64, stack word width in bits (fixed at 64; byte lanes = value_size/8)
- max_entries, 64, stack depth in words (512-byte eBPF stack at default)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_wr  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_addr  in  64  byte offset into the stack (0 = lowest byte)
- req_wdata  in  64  store data, right-aligned (only low 8<<req_size bits used)
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  64  load result, zero-extended; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; 1 = misaligned or out-of-range
- read_add  out  64  to stack read port, word index, upper bits 0
- data_out  in  64  from stack read port, valid one cycle after read_add is sampled
- wrt_add  out  64  to stack write port, word index
- wrt_en  out  1  stack write enable
- data_in  out  64  stack write data (full merged word)

## Operation
- Address split:
  - byte = req_addr[2:0]
  - word = req_addr[log2(max_entries)+2:3]
- Error when either:
  - req_addr >= max_entries*8, or
  - byte is not a multiple of (1<<req_size).
- Little-endian lanes: byte k of a word is bits [8k+7:8k].
- FSM states: IDLE, ERR, RD, WT, LDR, WR.
  - IDLE: req_ready=1. On req_valid, latch the request, then:
    - to ERR if the access is in error;
    - else to WR if it is a dword store;
    - else to RD.
  - ERR: resp_valid=1, resp_err=1. Next state IDLE. No memory access.
  - RD: read_add = latched word. Next state WT.
  - WT: capture data_out into the word register.
    - Loads: extract the field (shift right by 8*byte, mask to size) and go to LDR.
    - Stores: merge the size-masked wdata at byte offset and go to WR.
  - LDR: resp_valid=1, resp_data = extracted value. Next state IDLE.
  - WR: wrt_en=1, wrt_add = word, data_in = merged word (dword store: req_wdata unchanged); resp_valid=1, resp_err=0. Next state IDLE.
- Outputs when not in the active state:
  - wrt_en = 0, resp_valid = 0, resp_data = 0.
  - read_add holds its last value.
- Coherence:
  - A write in WR commits at that clock edge, so the next request's RD sees it.
  - Cross-lane same-word ordering is the issuer's responsibility; this unit does not arbitrate.

## Timing
- Request acceptance occurs in the cycle req_valid & req_ready (cycle 0).
- Latency from acceptance to resp_valid:
  - load: 3 cycles
  - partial store: 3 cycles
  - dword store: 1 cycle
  - error: 1 cycle
- Throughput: the next request is accepted in the cycle after resp_valid; one outstanding request maximum.
- resp has no back-pressure; the consumer must take it.
- Reset values: state = IDLE; resp_valid, resp_err, resp_data, wrt_en, wrt_add, data_in, read_add = 0.
- req_ready = 0 while reset is asserted, then 1 in IDLE.
- Reset mid-operation: abort immediately, no write issued, no response; the request is lost.
- req inputs are ignored outside IDLE.

## Structure
- Shared package `sephirot_stack_pkg` holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_DW
  - the FSM state typedef
  - STACK_BYTES = max_entries*8
  - function log2, shared with `stack`
- Sub-module `stack_byte_merge` (combinational) does extraction and merge: it takes word, byte offset, size and wdata, and returns the loaded field and the merged word.

## Test plan
- Dword store addr 0x10, data 0x1122334455667788: wrt_en in cycle 1, wrt_add=2, data_in equal to the data. Then a dword load of 0x10 gives resp_data=0x1122334455667788 at cycle 3.
- Byte store addr 0x13, data 0xAB, over the above word: data_in=0x11223344AB667788 in cycle 3, with read_add=2 in cycle 1.
- Half load addr 0x16 from word 0x11223344AB667788: resp_data=0x0000000000001122.
- Word load addr 0x12: resp_err=1 at cycle 1, with no read_add change and no wrt_en. Load addr 0x200: resp_err=1.
- Back-to-back: a byte store to 0x08 then a byte load from 0x08 in the next accepted request must return the stored byte; req_ready is low for 3 cycles per partial access.
- Assert reset in the WT cycle of a partial store: no wrt_en, no resp_valid, and all outputs are 0 during reset.
